key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 17 +
 rtl/key_event_if.sv | 29 ++
 rtl/key_timer.sv | 27 ++
 rtl/key_event.sv | 168 ++++++++++++++++
 tb/tb_key_event.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and one-hot state encodings for key_event
package key_pkg;

  localparam int CNT_W          = 26;
  localparam int LONG_CYC_DEF   = 50_000_000;
  localparam int DBL_CYC_DEF    = 15_000_000;
  localparam int REPEAT_CYC_DEF = 10_000_000;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_PRESS1 = 5'b00010,
    ST_WAIT2  = 5'b00100,
    ST_PRESS2 = 5'b01000,
    ST_LONG   = 5'b10000
  } key_fsm_t;

endpackage

// File: rtl/key_event_if.sv
// rtl/key_event_if.sv - key level in, click event pulses and hold level out
interface key_event_if;

  logic key_state;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic hold;

  modport master (
    output key_state,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  hold
  );

  modport slave (
    input  key_state,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output repeat_pulse,
    output hold
  );

endinterface

// File: rtl/key_timer.sv
// rtl/key_timer.sv - 26-bit phase counter with clear, enable and terminal compare
module key_timer
  import key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == i_term);

endmodule

// File: rtl/key_event.sv
// rtl/key_event.sv - key click classifier: short, double, long press and hold level
// Auto-repeat while held is built only when KEY_REPEAT_EN is defined.
module key_event
  import key_pkg::*;
#(
  parameter int LONG_CYC   = LONG_CYC_DEF,
  parameter int DBL_CYC    = DBL_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input logic        clk,
  input logic        rst,
  key_event_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYC - 1);

  key_fsm_t         r_state;
  key_fsm_t         w_state_nxt;
  logic             w_clr;
  logic             w_en;
  logic             w_done;
  logic [CNT_W-1:0] w_term;
  logic             w_short_nxt;
  logic             w_double_nxt;
  logic             w_long_nxt;
  logic             w_hold_nxt;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             r_hold;
`ifdef KEY_REPEAT_EN
  logic             w_wrap;
  logic             w_rep_nxt;
  logic             r_rep;
`endif

  key_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_term (w_term),
    .o_done (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = ST_IDLE;
    w_en         = 1'b0;
    w_term       = LONG_TERM;
    w_short_nxt  = 1'b0;
    w_double_nxt = 1'b0;
    w_long_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
    w_wrap       = 1'b0;
    w_rep_nxt    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = bus.key_state ? ST_PRESS1 : ST_IDLE;
      end
      ST_PRESS1: begin
        if (!bus.key_state) begin
          w_state_nxt = ST_WAIT2;
        end else if (w_done) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_PRESS1;
          w_en        = 1'b1;
        end
      end
      ST_WAIT2: begin
        w_term = DBL_TERM;
        if (bus.key_state) begin
          w_state_nxt = ST_PRESS2;
        end else if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_short_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT2;
          w_en        = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!bus.key_state) begin
          w_state_nxt  = ST_IDLE;
          w_double_nxt = 1'b1;
        end else if (w_done) begin
          w_state_nxt = ST_LONG;
          w_long_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_PRESS2;
          w_en        = 1'b1;
        end
      end
      ST_LONG: begin
        w_term = REP_TERM;
        if (!bus.key_state) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LONG;
`ifdef KEY_REPEAT_EN
          if (w_done) begin
            w_rep_nxt = 1'b1;
            w_wrap    = 1'b1;
          end else begin
            w_en = 1'b1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Every phase starts counting from zero; repeat wraps restart the period in place.
`ifdef KEY_REPEAT_EN
  assign w_clr = (w_state_nxt != r_state) || w_wrap;
`else
  assign w_clr = (w_state_nxt != r_state);
`endif
  assign w_hold_nxt = (w_state_nxt == ST_LONG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_hold   <= 1'b0;
    end else begin
      r_short  <= w_short_nxt;
      r_double <= w_double_nxt;
      r_long   <= w_long_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep <= 1'b0;
    end else begin
      r_rep <= w_rep_nxt;
    end
  end
  assign bus.repeat_pulse = r_rep;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

  assign bus.short_pulse  = r_short;
  assign bus.double_pulse = r_double;
  assign bus.long_pulse   = r_long;
  assign bus.hold         = r_hold;

endmodule

// File: tb/tb_key_event.sv
// tb/tb_key_event.sv - directed bench for key_event with a press/gap duration model
module tb_key_event;

  localparam int LONG = 20;
  localparam int DBL  = 10;
  localparam int REP  = 5;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  key_event_if kif();

  key_event #(.LONG_CYC(LONG), .DBL_CYC(DBL), .REPEAT_CYC(REP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic samp_key = 1'b0;
  logic samp_rst = 1'b1;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    samp_key <= kif.key_state;
    samp_rst <= rst;
  end

  // Model: lengths of the current press and of the gap after a first click.
  int m_len, m_gap, m_since;
  bit m_waiting, m_second, m_long;
  bit e_short, e_double, e_long, e_rep, e_hold;

  int n_short, n_double, n_long, n_rep, n_hold;
  int t_short, t_double, t_long;
  int rep_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_gap = 0; m_since = 0;
    m_waiting = 0; m_second = 0; m_long = 0;
    e_short = 0; e_double = 0; e_long = 0; e_rep = 0; e_hold = 0;
  endtask

  task automatic model_step(input logic k);
    e_short = 0; e_double = 0; e_long = 0; e_rep = 0;
    if (k) begin
      if (m_long) begin
        m_since++;
        if (REP_EN && (m_since % REP == 0)) e_rep = 1;
      end else if (m_len == LONG) begin
        m_long = 1; m_since = 0; e_long = 1;
      end else if (m_len == 0) begin
        m_second = m_waiting; m_waiting = 0; m_len = 1;
      end else begin
        m_len++;
      end
    end else begin
      if (m_long) begin
        m_long = 0; m_second = 0; m_len = 0;
      end else if (m_len > 0) begin
        if (m_second) begin
          e_double = 1; m_second = 0;
        end else begin
          m_waiting = 1; m_gap = 1;
        end
        m_len = 0;
      end else if (m_waiting) begin
        if (m_gap == DBL) begin
          e_short = 1; m_waiting = 0;
        end else begin
          m_gap++;
        end
      end
    end
    e_hold = m_long;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      else if (!samp_rst) model_step(samp_key);
      chk("short_pulse", kif.short_pulse, e_short);
      chk("double_pulse", kif.double_pulse, e_double);
      chk("long_pulse", kif.long_pulse, e_long);
      chk("repeat_pulse", kif.repeat_pulse, e_rep);
      chk("hold", kif.hold, e_hold);
      chk("pulse_onehot", int'($countones({kif.short_pulse, kif.double_pulse,
          kif.long_pulse, kif.repeat_pulse}) <= 1), 1);
      if (kif.short_pulse)  begin n_short++;  t_short  = cyc; end
      if (kif.double_pulse) begin n_double++; t_double = cyc; end
      if (kif.long_pulse)   begin n_long++;   t_long   = cyc; end
      if (kif.repeat_pulse) begin n_rep++; rep_q.push_back(cyc); end
      if (kif.hold) n_hold++;
    end
  end

  task automatic clr_log();
    n_short = 0; n_double = 0; n_long = 0; n_rep = 0; n_hold = 0;
    t_short = -1; t_double = -1; t_long = -1;
    rep_q.delete();
  endtask

  task automatic drive(input logic v, input int n);
    kif.key_state = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_short"}, kif.short_pulse, 0);
    chk({tag, "_double"}, kif.double_pulse, 0);
    chk({tag, "_long"}, kif.long_pulse, 0);
    chk({tag, "_repeat"}, kif.repeat_pulse, 0);
    chk({tag, "_hold"}, kif.hold, 0);
  endtask

  int t0;
  int exp_rep;

  initial begin
    rst = 1'b1;
    kif.key_state = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    drive(0, 3);

    // single short click
    clr_log(); t0 = cyc;
    drive(1, 5); drive(0, 15);
    chk("s1_n_short", n_short, 1);
    chk("s1_t_short", t_short, t0 + 16);
    chk("s1_n_other", n_double + n_long + n_rep, 0);

    // double click
    clr_log(); t0 = cyc;
    drive(1, 5); drive(0, 4); drive(1, 5); drive(0, 15);
    chk("s2_n_double", n_double, 1);
    chk("s2_t_double", t_double, t0 + 15);
    chk("s2_n_short", n_short, 0);

    // gap of exactly DBL low samples still counts as double
    clr_log(); t0 = cyc;
    drive(1, 3); drive(0, 10); drive(1, 3); drive(0, 15);
    chk("s3_n_double", n_double, 1);
    chk("s3_t_double", t_double, t0 + 17);
    chk("s3_n_short", n_short, 0);

    // gap one longer: two separate short clicks
    clr_log(); t0 = cyc;
    drive(1, 3); drive(0, 11); drive(1, 3); drive(0, 15);
    chk("s4_n_short", n_short, 2);
    chk("s4_t_short", t_short, t0 + 28);
    chk("s4_n_double", n_double, 0);

    // press of LONG samples is still short
    clr_log(); t0 = cyc;
    drive(1, 20); drive(0, 15);
    chk("s5_n_long", n_long, 0);
    chk("s5_n_short", n_short, 1);
    chk("s5_t_short", t_short, t0 + 31);

    // long press, hold level
    clr_log(); t0 = cyc;
    drive(1, 30); drive(0, 15);
    exp_rep = REP_EN ? 1 : 0;
    chk("s6_n_long", n_long, 1);
    chk("s6_t_long", t_long, t0 + 21);
    chk("s6_n_hold", n_hold, 10);
    chk("s6_n_click", n_short + n_double, 0);
    chk("s6_n_rep", n_rep, exp_rep);

    // auto-repeat while held
    clr_log(); t0 = cyc;
    drive(1, 36); drive(0, 15);
    exp_rep = REP_EN ? 3 : 0;
    chk("s7_t_long", t_long, t0 + 21);
    chk("s7_n_rep", n_rep, exp_rep);
    foreach (rep_q[i]) chk("s7_t_rep", rep_q[i], t0 + 26 + REP * i);
    chk("s7_n_hold", n_hold, 16);

    // second press held long: long, no double
    clr_log(); t0 = cyc;
    drive(1, 3); drive(0, 3); drive(1, 30); drive(0, 15);
    chk("s8_t_long", t_long, t0 + 27);
    chk("s8_n_click", n_short + n_double, 0);

    // reset during WAIT2
    clr_log();
    drive(1, 5); drive(0, 3);
    rst = 1'b1; #1;
    chk_zero("rst_wait2");
    drive(0, 2);
    rst = 1'b0;
    drive(0, 15);
    chk("s9_n_pulses", n_short + n_double + n_long + n_rep, 0);

    // reset during LONG, key still pressed at release of reset
    drive(1, 25);
    chk("s10_hold_before", kif.hold, 1);
    rst = 1'b1; #1;
    chk_zero("rst_long");
    clr_log();
    drive(1, 2);
    rst = 1'b0; t0 = cyc;
    drive(1, 25); drive(0, 10);
    chk("s10_n_long", n_long, 1);
    chk("s10_t_long", t_long, t0 + 21);
    chk("s10_n_other", n_short + n_double + n_rep, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
